// File: rtl/parent_call_agent_if.sv
// parent_call_agent_if: call request, command FIFO, return FIFO and status signals of one parent_call_agent
interface parent_call_agent_if #(
    parameter int ARG_W     = 32,
    parameter int ARG_NUM   = 4,
    parameter int RET_DW    = 32,
    parameter int CHILD     = 64,
    parameter int MAX_OUT   = 4,
    parameter int LOG_CHILD = (CHILD == 1) ? 1 : $clog2(CHILD),
    parameter int CMD_DW    = ARG_W * ARG_NUM + LOG_CHILD + 1 + 32,
    parameter int CNT_W     = $clog2(MAX_OUT + 1)
);
    logic                        call_vld_i;
    logic                        call_rdy_o;
    logic [LOG_CHILD-1:0]        call_child_i;
    logic                        call_ret_req_i;
    logic [31:0]                 call_pc_i;
    logic [ARG_W*ARG_NUM-1:0]    call_args_i;
    logic [CMD_DW-1:0]           cmd_din_o;
    logic                        cmd_write_o;
    logic                        cmd_full_n_i;
    logic                        ret_empty_n_i;
    logic [RET_DW+LOG_CHILD-1:0] ret_dout_i;
    logic                        ret_pop_o;
    logic                        ret_vld_o;
    logic                        ret_rdy_i;
    logic [RET_DW-1:0]           ret_data_o;
    logic [LOG_CHILD-1:0]        ret_child_o;
    logic [CNT_W-1:0]            outstanding_o;
    logic                        err_o;

    modport slave (
        input  call_vld_i, call_child_i, call_ret_req_i, call_pc_i, call_args_i,
        input  cmd_full_n_i, ret_empty_n_i, ret_dout_i, ret_rdy_i,
        output call_rdy_o, cmd_din_o, cmd_write_o, ret_pop_o, ret_vld_o,
        output ret_data_o, ret_child_o, outstanding_o, err_o
    );

    modport master (
        output call_vld_i, call_child_i, call_ret_req_i, call_pc_i, call_args_i,
        output cmd_full_n_i, ret_empty_n_i, ret_dout_i, ret_rdy_i,
        input  call_rdy_o, cmd_din_o, cmd_write_o, ret_pop_o, ret_vld_o,
        input  ret_data_o, ret_child_o, outstanding_o, err_o
    );
endinterface

// File: rtl/parent_call_agent.sv
// parent_call_agent: packs parent calls into arbiter commands, returns values in order under a credit limit
module parent_call_agent #(
    parameter int ARG_W   = 32,
    parameter int ARG_NUM = 4,
    parameter int RET_DW  = 32,
    parameter int CHILD   = 64,
    parameter int MAX_OUT = 4
) (
    input logic                clk,
    input logic                rst,
    parent_call_agent_if.slave bus
);
    localparam int LOG_CHILD = (CHILD == 1) ? 1 : $clog2(CHILD);
    localparam int ARGS_W    = ARG_W * ARG_NUM;
    localparam int CMD_DW    = ARGS_W + LOG_CHILD + 1 + 32;
    localparam int CNT_W     = $clog2(MAX_OUT + 1);
    localparam int PTR_W     = $clog2(MAX_OUT);

    logic                 cmd_hold_q, cmd_hold_d;
    logic [CMD_DW-1:0]    cmd_word_q, cmd_word_d;
    logic                 ret_vld_q, ret_vld_d;
    logic [RET_DW-1:0]    ret_data_q, ret_data_d;
    logic [LOG_CHILD-1:0] ret_child_q, ret_child_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                 err_q, err_d;
    logic [LOG_CHILD-1:0] tag_q [MAX_OUT];

    logic                 cmd_write, ret_pop, credit_ok, call_rdy, accept, push, pop_ok;
    logic [LOG_CHILD-1:0] ret_child_in;

    // Handshakes, credit check and next-state for command, return, credit and tag-queue state
    always_comb begin
        ret_child_in = bus.ret_dout_i[RET_DW+LOG_CHILD-1:RET_DW];
        cmd_write    = cmd_hold_q & bus.cmd_full_n_i;
        ret_pop      = bus.ret_empty_n_i & (~ret_vld_q | bus.ret_rdy_i);
        credit_ok    = (cnt_q < CNT_W'(MAX_OUT)) | ret_pop;
        call_rdy     = (~cmd_hold_q | cmd_write) & (~bus.call_ret_req_i | credit_ok);
        accept       = bus.call_vld_i & call_rdy;
        push         = accept & bus.call_ret_req_i;
        pop_ok       = ret_pop & (cnt_q != '0);
        cmd_hold_d   = accept | (cmd_hold_q & ~cmd_write);
        cmd_word_d   = accept ? {bus.call_pc_i, bus.call_ret_req_i, bus.call_child_i, bus.call_args_i} : cmd_word_q;
        ret_vld_d    = ret_pop | (ret_vld_q & ~bus.ret_rdy_i);
        ret_data_d   = ret_pop ? bus.ret_dout_i[RET_DW-1:0] : ret_data_q;
        ret_child_d  = ret_pop ? ret_child_in : ret_child_q;
        cnt_d        = cnt_q + CNT_W'(push) - CNT_W'(pop_ok);
        wr_ptr_d     = wr_ptr_q + PTR_W'(push);
        rd_ptr_d     = rd_ptr_q + PTR_W'(pop_ok);
        err_d        = err_q | (ret_pop & (~pop_ok | (ret_child_in != tag_q[rd_ptr_q])));
    end

    // State registers, all cleared immediately by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_hold_q  <= 1'b0;
            cmd_word_q  <= '0;
            ret_vld_q   <= 1'b0;
            ret_data_q  <= '0;
            ret_child_q <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            cmd_hold_q  <= cmd_hold_d;
            cmd_word_q  <= cmd_word_d;
            ret_vld_q   <= ret_vld_d;
            ret_data_q  <= ret_data_d;
            ret_child_q <= ret_child_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            err_q       <= err_d;
        end
    end

    // Tag queue storage; only the pointers matter after reset
    always_ff @(posedge clk) begin
        if (push) tag_q[wr_ptr_q] <= bus.call_child_i;
    end

    assign bus.call_rdy_o    = call_rdy;
    assign bus.cmd_write_o   = cmd_write;
    assign bus.cmd_din_o     = cmd_word_q;
    assign bus.ret_pop_o     = ret_pop;
    assign bus.ret_vld_o     = ret_vld_q;
    assign bus.ret_data_o    = ret_data_q;
    assign bus.ret_child_o   = ret_child_q;
    assign bus.outstanding_o = cnt_q;
    assign bus.err_o         = err_q;
endmodule

// File: tb/tb_parent_call_agent.sv
// tb_parent_call_agent: directed scenario tests for parent_call_agent
module tb_parent_call_agent;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    parent_call_agent_if bus ();
    parent_call_agent dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        tests++; if (bus.call_rdy_o !== 1'b1) begin fails++; $display("FAIL rst_call_rdy got=%0h exp=1", bus.call_rdy_o); end
        tests++; if (bus.cmd_write_o !== 1'b0) begin fails++; $display("FAIL rst_cmd_write got=%0h exp=0", bus.cmd_write_o); end
        tests++; if (bus.cmd_din_o !== '0) begin fails++; $display("FAIL rst_cmd_din got=%0h exp=0", bus.cmd_din_o); end
        tests++; if (bus.ret_pop_o !== 1'b0) begin fails++; $display("FAIL rst_ret_pop got=%0h exp=0", bus.ret_pop_o); end
        tests++; if (bus.ret_vld_o !== 1'b0) begin fails++; $display("FAIL rst_ret_vld got=%0h exp=0", bus.ret_vld_o); end
        tests++; if (bus.ret_data_o !== '0) begin fails++; $display("FAIL rst_ret_data got=%0h exp=0", bus.ret_data_o); end
        tests++; if (bus.ret_child_o !== '0) begin fails++; $display("FAIL rst_ret_child got=%0h exp=0", bus.ret_child_o); end
        tests++; if (bus.outstanding_o !== '0) begin fails++; $display("FAIL rst_outstanding got=%0h exp=0", bus.outstanding_o); end
        tests++; if (bus.err_o !== 1'b0) begin fails++; $display("FAIL rst_err got=%0h exp=0", bus.err_o); end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_call();
        logic [166:0] w;
        w = {32'h1000, 1'b1, 6'd5, 32'd4, 32'd3, 32'd2, 32'd1};
        bus.call_vld_i = 1'b1; bus.call_ret_req_i = 1'b1; bus.call_child_i = 6'd5;
        bus.call_pc_i = 32'h1000; bus.call_args_i = {32'd4, 32'd3, 32'd2, 32'd1};
        #1;
        tests++; if (bus.call_rdy_o !== 1'b1) begin fails++; $display("FAIL single_rdy got=%0h exp=1", bus.call_rdy_o); end
        step();
        bus.call_vld_i = 1'b0;
        tests++; if (bus.cmd_write_o !== 1'b1) begin fails++; $display("FAIL single_write got=%0h exp=1", bus.cmd_write_o); end
        tests++; if (bus.cmd_din_o !== w) begin fails++; $display("FAIL single_word got=%0h exp=%0h", bus.cmd_din_o, w); end
        tests++; if (bus.outstanding_o !== 3'd1) begin fails++; $display("FAIL single_outstanding got=%0h exp=1", bus.outstanding_o); end
        step();
        tests++; if (bus.cmd_write_o !== 1'b0) begin fails++; $display("FAIL single_write_done got=%0h exp=0", bus.cmd_write_o); end
        bus.ret_empty_n_i = 1'b1; bus.ret_dout_i = {6'd5, 32'h0000ABCD};
        #1;
        tests++; if (bus.ret_pop_o !== 1'b1) begin fails++; $display("FAIL single_pop got=%0h exp=1", bus.ret_pop_o); end
        step();
        bus.ret_empty_n_i = 1'b0;
        tests++; if (bus.ret_vld_o !== 1'b1) begin fails++; $display("FAIL single_ret_vld got=%0h exp=1", bus.ret_vld_o); end
        tests++; if (bus.ret_data_o !== 32'hABCD) begin fails++; $display("FAIL single_ret_data got=%0h exp=abcd", bus.ret_data_o); end
        tests++; if (bus.ret_child_o !== 6'd5) begin fails++; $display("FAIL single_ret_child got=%0h exp=5", bus.ret_child_o); end
        tests++; if (bus.outstanding_o !== 3'd0) begin fails++; $display("FAIL single_out_after got=%0h exp=0", bus.outstanding_o); end
        tests++; if (bus.err_o !== 1'b0) begin fails++; $display("FAIL single_err got=%0h exp=0", bus.err_o); end
        step();
        tests++; if (bus.ret_vld_o !== 1'b0) begin fails++; $display("FAIL single_ret_clear got=%0h exp=0", bus.ret_vld_o); end
    endtask

    task automatic test_credit_limit();
        logic [5:0] exp_ch [4];
        exp_ch = '{6'd2, 6'd3, 6'd4, 6'd9};
        bus.call_vld_i = 1'b1; bus.call_ret_req_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.call_child_i = 6'(i);
            step();
        end
        tests++; if (bus.outstanding_o !== 3'd4) begin fails++; $display("FAIL credit_full got=%0h exp=4", bus.outstanding_o); end
        bus.call_child_i = 6'd9;
        #1;
        tests++; if (bus.call_rdy_o !== 1'b0) begin fails++; $display("FAIL credit_block got=%0h exp=0", bus.call_rdy_o); end
        step();
        tests++; if (bus.outstanding_o !== 3'd4) begin fails++; $display("FAIL credit_hold got=%0h exp=4", bus.outstanding_o); end
        tests++; if (bus.cmd_write_o !== 1'b0) begin fails++; $display("FAIL credit_no_write got=%0h exp=0", bus.cmd_write_o); end
        bus.ret_empty_n_i = 1'b1; bus.ret_dout_i = {6'd1, 32'h11};
        #1;
        tests++; if (bus.ret_pop_o !== 1'b1) begin fails++; $display("FAIL credit_pop got=%0h exp=1", bus.ret_pop_o); end
        tests++; if (bus.call_rdy_o !== 1'b1) begin fails++; $display("FAIL credit_rdy_on_pop got=%0h exp=1", bus.call_rdy_o); end
        step();
        bus.call_vld_i = 1'b0; bus.ret_empty_n_i = 1'b0;
        tests++; if (bus.outstanding_o !== 3'd4) begin fails++; $display("FAIL credit_swap got=%0h exp=4", bus.outstanding_o); end
        tests++; if (bus.cmd_write_o !== 1'b1) begin fails++; $display("FAIL credit_fifth_write got=%0h exp=1", bus.cmd_write_o); end
        tests++; if (bus.ret_child_o !== 6'd1) begin fails++; $display("FAIL credit_ret_child got=%0h exp=1", bus.ret_child_o); end
        for (int i = 0; i < 4; i++) begin
            bus.ret_empty_n_i = 1'b1; bus.ret_dout_i = {exp_ch[i], 32'(32'h20 + i)};
            step();
        end
        bus.ret_empty_n_i = 1'b0;
        tests++; if (bus.outstanding_o !== 3'd0) begin fails++; $display("FAIL credit_drain got=%0h exp=0", bus.outstanding_o); end
        tests++; if (bus.err_o !== 1'b0) begin fails++; $display("FAIL credit_err got=%0h exp=0", bus.err_o); end
        tests++; if (bus.ret_child_o !== 6'd9) begin fails++; $display("FAIL credit_last_child got=%0h exp=9", bus.ret_child_o); end
        tests++; if (bus.ret_data_o !== 32'h23) begin fails++; $display("FAIL credit_last_data got=%0h exp=23", bus.ret_data_o); end
        step();
    endtask

    task automatic test_backpressure();
        logic [166:0] w1, w2;
        w1 = {32'h2000, 1'b0, 6'd3, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
        w2 = {32'h3000, 1'b0, 6'd8, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
        bus.cmd_full_n_i = 1'b0;
        bus.call_vld_i = 1'b1; bus.call_ret_req_i = 1'b0; bus.call_child_i = 6'd3;
        bus.call_pc_i = 32'h2000; bus.call_args_i = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        #1;
        tests++; if (bus.call_rdy_o !== 1'b1) begin fails++; $display("FAIL bp_first_rdy got=%0h exp=1", bus.call_rdy_o); end
        step();
        bus.call_pc_i = 32'h3000; bus.call_child_i = 6'd8;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (bus.cmd_write_o !== 1'b0) begin fails++; $display("FAIL bp_write%0d got=%0h exp=0", i, bus.cmd_write_o); end
            tests++; if (bus.call_rdy_o !== 1'b0) begin fails++; $display("FAIL bp_rdy%0d got=%0h exp=0", i, bus.call_rdy_o); end
            tests++; if (bus.cmd_din_o !== w1) begin fails++; $display("FAIL bp_word%0d got=%0h exp=%0h", i, bus.cmd_din_o, w1); end
            step();
        end
        bus.cmd_full_n_i = 1'b1;
        #1;
        tests++; if (bus.cmd_write_o !== 1'b1) begin fails++; $display("FAIL bp_release_write got=%0h exp=1", bus.cmd_write_o); end
        tests++; if (bus.call_rdy_o !== 1'b1) begin fails++; $display("FAIL bp_release_rdy got=%0h exp=1", bus.call_rdy_o); end
        step();
        bus.call_vld_i = 1'b0;
        tests++; if (bus.cmd_din_o !== w2) begin fails++; $display("FAIL bp_second_word got=%0h exp=%0h", bus.cmd_din_o, w2); end
        tests++; if (bus.cmd_write_o !== 1'b1) begin fails++; $display("FAIL bp_second_write got=%0h exp=1", bus.cmd_write_o); end
        tests++; if (bus.outstanding_o !== 3'd0) begin fails++; $display("FAIL bp_no_credit got=%0h exp=0", bus.outstanding_o); end
        step();
        tests++; if (bus.cmd_write_o !== 1'b0) begin fails++; $display("FAIL bp_idle got=%0h exp=0", bus.cmd_write_o); end
    endtask

    task automatic test_return_stall();
        bus.ret_rdy_i = 1'b0;
        bus.call_vld_i = 1'b1; bus.call_ret_req_i = 1'b1;
        for (int i = 10; i <= 12; i++) begin
            bus.call_child_i = 6'(i);
            step();
        end
        bus.call_vld_i = 1'b0;
        step();
        tests++; if (bus.outstanding_o !== 3'd3) begin fails++; $display("FAIL stall_out got=%0h exp=3", bus.outstanding_o); end
        bus.ret_empty_n_i = 1'b1; bus.ret_dout_i = {6'd10, 32'hA0};
        #1;
        tests++; if (bus.ret_pop_o !== 1'b1) begin fails++; $display("FAIL stall_first_pop got=%0h exp=1", bus.ret_pop_o); end
        step();
        bus.ret_dout_i = {6'd11, 32'hB0};
        #1;
        tests++; if (bus.ret_pop_o !== 1'b0) begin fails++; $display("FAIL stall_no_pop got=%0h exp=0", bus.ret_pop_o); end
        step();
        step();
        tests++; if (bus.ret_vld_o !== 1'b1) begin fails++; $display("FAIL stall_vld got=%0h exp=1", bus.ret_vld_o); end
        tests++; if (bus.ret_data_o !== 32'hA0) begin fails++; $display("FAIL stall_data got=%0h exp=a0", bus.ret_data_o); end
        tests++; if (bus.ret_child_o !== 6'd10) begin fails++; $display("FAIL stall_child got=%0h exp=a", bus.ret_child_o); end
        tests++; if (bus.outstanding_o !== 3'd2) begin fails++; $display("FAIL stall_out2 got=%0h exp=2", bus.outstanding_o); end
        bus.ret_rdy_i = 1'b1;
        #1;
        tests++; if (bus.ret_pop_o !== 1'b1) begin fails++; $display("FAIL stall_resume_pop got=%0h exp=1", bus.ret_pop_o); end
        step();
        tests++; if (bus.ret_data_o !== 32'hB0) begin fails++; $display("FAIL stall_data2 got=%0h exp=b0", bus.ret_data_o); end
        bus.ret_dout_i = {6'd12, 32'hC0};
        step();
        bus.ret_empty_n_i = 1'b0;
        tests++; if (bus.ret_data_o !== 32'hC0) begin fails++; $display("FAIL stall_data3 got=%0h exp=c0", bus.ret_data_o); end
        tests++; if (bus.outstanding_o !== 3'd0) begin fails++; $display("FAIL stall_out0 got=%0h exp=0", bus.outstanding_o); end
        tests++; if (bus.err_o !== 1'b0) begin fails++; $display("FAIL stall_err got=%0h exp=0", bus.err_o); end
        step();
        tests++; if (bus.ret_vld_o !== 1'b0) begin fails++; $display("FAIL stall_clear got=%0h exp=0", bus.ret_vld_o); end
    endtask

    task automatic test_mismatch();
        bus.call_vld_i = 1'b1; bus.call_ret_req_i = 1'b1; bus.call_child_i = 6'd2;
        step();
        bus.call_vld_i = 1'b0;
        step();
        bus.ret_empty_n_i = 1'b1; bus.ret_dout_i = {6'd7, 32'h99};
        step();
        bus.ret_empty_n_i = 1'b0;
        tests++; if (bus.err_o !== 1'b1) begin fails++; $display("FAIL mm_err got=%0h exp=1", bus.err_o); end
        tests++; if (bus.outstanding_o !== 3'd0) begin fails++; $display("FAIL mm_out got=%0h exp=0", bus.outstanding_o); end
        tests++; if (bus.ret_child_o !== 6'd7) begin fails++; $display("FAIL mm_child got=%0h exp=7", bus.ret_child_o); end
        step();
        step();
        tests++; if (bus.err_o !== 1'b1) begin fails++; $display("FAIL mm_sticky got=%0h exp=1", bus.err_o); end
    endtask

    task automatic test_async_reset();
        bus.ret_rdy_i = 1'b0; bus.cmd_full_n_i = 1'b0;
        bus.call_vld_i = 1'b1; bus.call_ret_req_i = 1'b1; bus.call_child_i = 6'd4;
        bus.ret_empty_n_i = 1'b1; bus.ret_dout_i = {6'd1, 32'h55};
        step();
        bus.call_vld_i = 1'b0; bus.ret_empty_n_i = 1'b0;
        tests++; if (bus.outstanding_o !== 3'd1) begin fails++; $display("FAIL ar_pre_out got=%0h exp=1", bus.outstanding_o); end
        tests++; if (bus.ret_vld_o !== 1'b1) begin fails++; $display("FAIL ar_pre_vld got=%0h exp=1", bus.ret_vld_o); end
        tests++; if (bus.cmd_write_o !== 1'b0) begin fails++; $display("FAIL ar_pre_write got=%0h exp=0", bus.cmd_write_o); end
        #2;
        rst = 1'b1;
        #1;
        tests++; if (bus.cmd_write_o !== 1'b0) begin fails++; $display("FAIL ar_write got=%0h exp=0", bus.cmd_write_o); end
        tests++; if (bus.cmd_din_o !== '0) begin fails++; $display("FAIL ar_din got=%0h exp=0", bus.cmd_din_o); end
        tests++; if (bus.ret_vld_o !== 1'b0) begin fails++; $display("FAIL ar_vld got=%0h exp=0", bus.ret_vld_o); end
        tests++; if (bus.ret_data_o !== '0) begin fails++; $display("FAIL ar_data got=%0h exp=0", bus.ret_data_o); end
        tests++; if (bus.ret_child_o !== '0) begin fails++; $display("FAIL ar_child got=%0h exp=0", bus.ret_child_o); end
        tests++; if (bus.outstanding_o !== '0) begin fails++; $display("FAIL ar_out got=%0h exp=0", bus.outstanding_o); end
        tests++; if (bus.err_o !== 1'b0) begin fails++; $display("FAIL ar_err got=%0h exp=0", bus.err_o); end
        tests++; if (bus.ret_pop_o !== 1'b0) begin fails++; $display("FAIL ar_pop got=%0h exp=0", bus.ret_pop_o); end
        bus.cmd_full_n_i = 1'b1;
        #1;
        tests++; if (bus.cmd_write_o !== 1'b0) begin fails++; $display("FAIL ar_full_write got=%0h exp=0", bus.cmd_write_o); end
        step();
        tests++; if (bus.cmd_write_o !== 1'b0) begin fails++; $display("FAIL ar_edge_write got=%0h exp=0", bus.cmd_write_o); end
        rst = 1'b0;
        #1;
        tests++; if (bus.cmd_write_o !== 1'b0) begin fails++; $display("FAIL ar_post_write got=%0h exp=0", bus.cmd_write_o); end
        tests++; if (bus.call_rdy_o !== 1'b1) begin fails++; $display("FAIL ar_post_rdy got=%0h exp=1", bus.call_rdy_o); end
        step();
    endtask

    task automatic test_unexpected_return();
        bus.ret_rdy_i = 1'b1; bus.ret_empty_n_i = 1'b1; bus.ret_dout_i = {6'd9, 32'h77};
        #1;
        tests++; if (bus.ret_pop_o !== 1'b1) begin fails++; $display("FAIL ux_pop got=%0h exp=1", bus.ret_pop_o); end
        step();
        bus.ret_empty_n_i = 1'b0;
        tests++; if (bus.err_o !== 1'b1) begin fails++; $display("FAIL ux_err got=%0h exp=1", bus.err_o); end
        tests++; if (bus.ret_vld_o !== 1'b1) begin fails++; $display("FAIL ux_vld got=%0h exp=1", bus.ret_vld_o); end
        tests++; if (bus.ret_data_o !== 32'h77) begin fails++; $display("FAIL ux_data got=%0h exp=77", bus.ret_data_o); end
        tests++; if (bus.ret_child_o !== 6'd9) begin fails++; $display("FAIL ux_child got=%0h exp=9", bus.ret_child_o); end
        tests++; if (bus.outstanding_o !== 3'd0) begin fails++; $display("FAIL ux_out got=%0h exp=0", bus.outstanding_o); end
    endtask

    initial begin
        bus.call_vld_i = 1'b0; bus.call_child_i = '0; bus.call_ret_req_i = 1'b0;
        bus.call_pc_i = '0; bus.call_args_i = '0; bus.cmd_full_n_i = 1'b1;
        bus.ret_empty_n_i = 1'b0; bus.ret_dout_i = '0; bus.ret_rdy_i = 1'b1;
        test_reset();
        test_single_call();
        test_credit_limit();
        test_backpressure();
        test_return_stall();
        test_mismatch();
        test_async_reset();
        test_unexpected_return();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
